// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch buffer: DEPTH entries of {pc, instr, err}, registered head
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  fetch_entry_t           wr_entry,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_pop;

   assign do_pop = pop & (count != '0);

   // Storage is reset too so the head reads as all-zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage, one outstanding imem request, FIFO to decode
// FETCH_MISALIGN_CHECK_EN: misaligned PCs push an error entry instead of fetching.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] pc_plus_4,
   output logic        pc_hold,
   input  logic        flush,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus_4,
   output logic [31:0] id_instr,
   output logic        id_err
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = CW + 1;

   fetch_state_e  state;
   fetch_state_e  state_next;
   logic [31:0]   req_pc;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic          push;
   logic          pop;
   logic          busy;
   logic          room;
   logic          mis;
   logic          mis_push;
   logic          issue_slot;
   logic          fire;

   assign busy = (state != IDLE);
   assign pop  = id_valid & id_ready;

   // A head consumed this cycle frees its slot, so back-to-back issue keeps
   // one instruction per cycle flowing with only two entries.
   assign room = ({1'b0, count} + RW'(busy)) < (RW'(DEPTH) + RW'(pop));

`ifdef FETCH_MISALIGN_CHECK_EN
   assign mis = (pc[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   assign issue_slot     = !flush & room & ((state == IDLE) | ((state == WAIT) & imem_rsp_valid));
   assign imem_req_valid = !rst & issue_slot & !mis;
   assign mis_push       = !rst & !flush & room & (state == IDLE) & mis;
   assign fire           = imem_req_valid & imem_req_ready;
   assign pc_hold        = rst | (!fire & !flush & !mis_push);

   assign imem_addr = {pc[31:2], 2'b00};
   assign pc_plus_4 = pc + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         req_pc <= '0;
      end else begin
         state <= state_next;
         if (fire) begin
            req_pc <= pc;
         end
      end
   end

   always_comb begin
      state_next = state;
      push       = 1'b0;
      push_entry = '{pc: req_pc, instr: imem_rsp_data, err: 1'b0};
      case (state)
         IDLE: begin
            if (mis_push) begin
               push       = 1'b1;
               push_entry = '{pc: pc, instr: FETCH_NOP, err: 1'b1};
            end else if (fire) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_next = imem_rsp_valid ? IDLE : DRAIN;
            end else if (imem_rsp_valid) begin
               push       = 1'b1;
               state_next = fire ? WAIT : IDLE;
            end
         end
         DRAIN: begin
            // The killed request's response is swallowed here.
            if (imem_rsp_valid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .clear    (flush),
      .wr_entry (push_entry),
      .head     (head),
      .count    (count)
   );

   assign id_valid     = (count != '0);
   assign id_pc        = head.pc;
   assign id_pc_plus_4 = head.pc + 32'd4;
   assign id_instr     = head.instr;
   assign id_err       = head.err;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed bench for fetch_stage against a PC/memory/stream model
module tb_fetch_stage;

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] pc_plus_4;
   logic        pc_hold;
   logic        flush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus_4;
   logic [31:0] id_instr;
   logic        id_err;

   int          vectors = 0;
   int          miscompares = 0;
   int          n_pops = 0;

   int          mem_k;
   logic        mem_pend;
   int          mem_dly;
   logic [31:0] mem_addr;
   logic [31:0] exp_pc;
   logic [31:0] flush_target;

   logic        s_fire, s_pop, s_req_valid, s_pc_hold, s_id_valid, s_id_err;
   logic [31:0] s_addr, s_id_pc, s_id_pc4;

   fetch_stage #(
      .DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_plus_4      (pc_plus_4),
      .pc_hold        (pc_hold),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_pc_plus_4   (id_pc_plus_4),
      .id_instr       (id_instr),
      .id_err         (id_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic err_of(input logic [31:0] p);
      return MIS_EN && (p[1:0] != 2'b00);
   endfunction

   // One clock cycle: memory answers, outputs are sampled mid-low-phase,
   // then the PC, memory and expected-stream models advance.
   task automatic tick();
      logic        rsp_now;
      logic [31:0] e_instr;
      rsp_now        = mem_pend && (mem_dly == 0);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? instr_of(mem_addr) : 32'hDEAD_BEEF;
      #1;
      s_fire      = imem_req_valid & imem_req_ready;
      s_pop       = id_valid & id_ready;
      s_req_valid = imem_req_valid;
      s_pc_hold   = pc_hold;
      s_addr      = imem_addr;
      s_id_valid  = id_valid;
      s_id_pc     = id_pc;
      s_id_pc4    = id_pc_plus_4;
      s_id_err    = id_err;
      if (s_fire) begin
         vectors++;
         if (imem_addr !== {pc[31:2], 2'b00}) begin
            miscompares++;
            $display("FAIL req_addr: got %h want %h", imem_addr, {pc[31:2], 2'b00});
         end
      end
      if (s_pop) begin
         n_pops++;
         e_instr = err_of(exp_pc) ? 32'h0 : instr_of({exp_pc[31:2], 2'b00});
         vectors++;
         if (id_pc !== exp_pc || id_instr !== e_instr || id_pc_plus_4 !== exp_pc + 32'd4 ||
             id_err !== err_of(exp_pc)) begin
            miscompares++;
            $display("FAIL pop: got pc=%h instr=%h pc4=%h err=%b want pc=%h instr=%h pc4=%h err=%b",
                     id_pc, id_instr, id_pc_plus_4, id_err, exp_pc, e_instr, exp_pc + 32'd4,
                     err_of(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
      end
      if (flush) exp_pc = flush_target;
      @(posedge clk);
      @(negedge clk);
      if (rsp_now) mem_pend = 1'b0;
      else if (mem_pend) mem_dly--;
      if (s_fire) begin
         mem_pend = 1'b1;
         mem_addr = s_addr;
         mem_dly  = (mem_k == 0) ? int'($urandom_range(3, 0)) : mem_k - 1;
      end
      if (!s_pc_hold) pc = flush ? flush_target : pc + 32'd4;
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      rst            = 1'b1;
      flush          = 1'b0;
      flush_target   = 32'h0;
      pc             = start_pc;
      exp_pc         = start_pc;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      mem_pend       = 1'b0;
      mem_dly        = 0;
      mem_addr       = 32'h0;
      mem_k          = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; pc = 32'h0; id_ready = 1'b1;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      #1;
      vectors++;
      if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || id_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_id: got v=%b pc=%h instr=%h err=%b want all 0", id_valid, id_pc, id_instr, id_err);
      end
      vectors++;
      if (imem_req_valid !== 1'b0 || pc_hold !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_req: got req_valid=%b pc_hold=%b want 0/1", imem_req_valid, pc_hold);
      end
      // Fill the FIFO, then reset asynchronously mid-cycle.
      do_reset(32'h200);
      id_ready = 1'b0;
      repeat (4) tick();
      vectors++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'h200) begin
         miscompares++;
         $display("FAIL prefill: got v=%b pc=%h want 1/00000200", s_id_valid, s_id_pc);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (id_valid !== 1'b0 || id_pc !== 32'h0 || imem_req_valid !== 1'b0 || pc_hold !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b pc=%h req=%b hold=%b want 0/0/0/1",
                  id_valid, id_pc, imem_req_valid, pc_hold);
      end
      @(negedge clk);
   endtask

   task automatic test_stream();
      logic [31:0] want_addr [3];
      want_addr = '{32'h0, 32'h4, 32'h8};
      do_reset(32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (s_fire !== 1'b1 || s_addr !== want_addr[i]) begin
            miscompares++;
            $display("FAIL stream_issue%0d: got fire=%b addr=%h want 1/%h", i, s_fire, s_addr, want_addr[i]);
         end
      end
      vectors++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL stream_first: got v=%b pc=%h want 1/00000000", s_id_valid, s_id_pc);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (s_fire !== 1'b1 || s_pop !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_rate%0d: got fire=%b pop=%b want 1/1", i, s_fire, s_pop);
         end
      end
   endtask

   task automatic test_stall();
      do_reset(32'h0);
      id_ready = 1'b0;
      repeat (6) tick();
      vectors++;
      if (s_req_valid !== 1'b0 || s_pc_hold !== 1'b1 || s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL stall: got req=%b hold=%b v=%b pc=%h want 0/1/1/00000000",
                  s_req_valid, s_pc_hold, s_id_valid, s_id_pc);
      end
      id_ready = 1'b1;
      repeat (10) tick();
      vectors++;
      if (n_pops < 10) begin
         miscompares++;
         $display("FAIL stall_resume: got %0d pops want at least 10", n_pops);
      end
   endtask

   task automatic test_flush();
      bit found;
      do_reset(32'h0);
      mem_k = 3;
      tick();
      flush = 1'b1; flush_target = 32'h40;
      tick();
      flush = 1'b0;
      vectors++;
      if (s_fire !== 1'b0 || s_pc_hold !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_cycle: got fire=%b hold=%b want 0/0", s_fire, s_pc_hold);
      end
      tick();
      vectors++;
      if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain1: got req=%b v=%b want 0/0", s_req_valid, s_id_valid);
      end
      tick();
      vectors++;
      if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain2: got req=%b v=%b want 0/0", s_req_valid, s_id_valid);
      end
      tick();
      vectors++;
      if (s_fire !== 1'b1 || s_addr !== 32'h40) begin
         miscompares++;
         $display("FAIL redirect_issue: got fire=%b addr=%h want 1/00000040", s_fire, s_addr);
      end
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (s_pop) begin
            found = 1'b1;
            vectors++;
            if (s_id_pc !== 32'h40) begin
               miscompares++;
               $display("FAIL redirect_first: got pc=%h want 00000040", s_id_pc);
            end
         end
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL redirect_timeout: got no pop want pop within 12 cycles");
      end
   endtask

   task automatic test_req_ready();
      do_reset(32'h10);
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (s_req_valid !== 1'b1 || s_pc_hold !== 1'b1 || s_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL req_stall%0d: got req=%b hold=%b addr=%h want 1/1/00000010",
                     i, s_req_valid, s_pc_hold, s_addr);
         end
      end
      imem_req_ready = 1'b1;
      tick();
      vectors++;
      if (s_fire !== 1'b1 || s_addr !== 32'h10) begin
         miscompares++;
         $display("FAIL req_release: got fire=%b addr=%h want 1/00000010", s_fire, s_addr);
      end
      repeat (6) tick();
   endtask

   task automatic test_wrap();
      do_reset(32'hFFFF_FFFC);
      #1;
      vectors++;
      if (pc_plus_4 !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_pc4: got %h want 00000000", pc_plus_4);
      end
      repeat (3) tick();
      vectors++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'hFFFF_FFFC || s_id_pc4 !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_id: got v=%b pc=%h pc4=%h want 1/fffffffc/00000000",
                  s_id_valid, s_id_pc, s_id_pc4);
      end
      repeat (3) tick();
   endtask

   task automatic test_misalign();
      do_reset(32'h6);
      tick();
      vectors++;
      if (s_req_valid !== 1'b0 || s_pc_hold !== 1'b0) begin
         miscompares++;
         $display("FAIL misalign_req: got req=%b hold=%b want 0/0", s_req_valid, s_pc_hold);
      end
      tick();
      vectors++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'h6 || s_id_err !== 1'b1) begin
         miscompares++;
         $display("FAIL misalign_entry: got v=%b pc=%h err=%b want 1/00000006/1", s_id_valid, s_id_pc, s_id_err);
      end
   endtask

   task automatic test_random();
      int pops_before;
      do_reset(32'h100);
      mem_k       = 0;
      pops_before = n_pops;
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         id_ready       = ($urandom_range(3, 0) != 0);
         flush          = ($urandom_range(31, 0) == 0);
         flush_target   = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      flush = 1'b0;
      vectors++;
      if (n_pops - pops_before < 300) begin
         miscompares++;
         $display("FAIL random_progress: got %0d pops want at least 300", n_pops - pops_before);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_req_ready();
      test_wrap();
      if (MIS_EN) test_misalign();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
